// File: rtl/data_mem_responder_pkg.sv
// Shared types for the CPU data-memory responder: the access-mode
// encodings mirror the MMD field of the ISA so the CPU and memory agree.
package data_mem_responder_pkg;

  localparam int MMD = 3;

  typedef enum logic [MMD-1:0] {
    MMD_BS = 3'd0,  // byte, sign-extended
    MMD_BU = 3'd1,  // byte, zero-extended
    MMD_HS = 3'd2,  // half, sign-extended
    MMD_HU = 3'd3,  // half, zero-extended
    MMD_W  = 3'd4   // full word
  } mmd_t;

endpackage

// File: rtl/mem_lane_align.sv
// Lane steering for one 32-bit memory word: byte enables and replicated
// store data for writes, extended load data for reads, misalignment flag.
module mem_lane_align
  import data_mem_responder_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [31:0] wr_data,
  input  logic [1:0]  lane,
  input  mmd_t        mode,
  output logic [3:0]  byte_en,
  output logic [31:0] wr_lanes,
  output logic [31:0] rd_ext,
  output logic        misaligned
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  // Pick the addressed lane, extend it, and steer store data onto every lane.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    rd_byte    = rd_word[{lane, 3'b000} +: 8];
    rd_half    = lane[1] ? rd_word[31:16] : rd_word[15:0];
    byte_en    = 4'b1111;
    wr_lanes   = wr_data;
    rd_ext     = rd_word;
    misaligned = 1'b0;
    case (mode)
      MMD_BS, MMD_BU: begin
        byte_en  = 4'b0001 << lane;
        wr_lanes = {4{wr_data[7:0]}};
        rd_ext   = {{24{(mode == MMD_BS) & rd_byte[7]}}, rd_byte};
      end
      MMD_HS, MMD_HU: begin
        byte_en    = lane[1] ? 4'b1100 : 4'b0011;
        wr_lanes   = {2{wr_data[15:0]}};
        rd_ext     = {{16{(mode == MMD_HS) & rd_half[15]}}, rd_half};
        misaligned = lane[0];
      end
      default: begin
        misaligned = (lane != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder for the pipelined CPU: services load/store requests
// from a word array with LATENCY stall cycles (0 = zero-wait memory).
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int LATENCY     = 2,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  input  mmd_t        mode,
  input  logic        memRead,
  input  logic        memWrite,
  output logic [31:0] readData,
  output logic        stall,
  output logic        alignErr
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW+1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  mmd_t          mode_q, mode_d;
  logic          rd_q, rd_d, wr_q, wr_d, err_q, err_d;
  logic [31:0]   read_data_q, read_data_d;

  logic          req, live, commit, mem_we;
  logic [AW+1:0] addr_s;
  logic [31:0]   wdata_s, word_s, wr_lanes, rd_ext;
  mmd_t          mode_s;
  logic          rd_s, wr_s, err_s, misaligned;
  logic [3:0]    be;
  logic [31:0]   mem [DEPTH_WORDS];

  // Upper address bits wrap around and are deliberately ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^address[31:AW+2];

  assign req  = memRead | memWrite;
  assign live = (LATENCY == 0) || (state_q == S_IDLE);

  // Request fields come straight from the CPU at accept, from the latch afterwards.
  always_comb begin
    if (live) begin
      addr_s  = address[AW+1:0];
      wdata_s = writeData;
      mode_s  = mode;
      rd_s    = memRead;
      wr_s    = memWrite;
    end else begin
      addr_s  = addr_q;
      wdata_s = wdata_q;
      mode_s  = mode_q;
      rd_s    = rd_q;
      wr_s    = wr_q;
    end
  end

  assign word_s = mem[addr_s[AW+1:2]];

  mem_lane_align u_align (
    .rd_word    (word_s),
    .wr_data    (wdata_s),
    .lane       (addr_s[1:0]),
    .mode       (mode_s),
    .byte_en    (be),
    .wr_lanes   (wr_lanes),
    .rd_ext     (rd_ext),
    .misaligned (misaligned)
  );

  assign err_s = misaligned | (rd_s & wr_s);

  // Next-state logic: accept in IDLE, count down in WAIT, commit on the last stall cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mode_d      = mode_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    commit      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req && (LATENCY > 0)) begin
          addr_d  = address[AW+1:0];
          wdata_d = writeData;
          mode_d  = mode;
          rd_d    = memRead;
          wr_d    = memWrite;
          if (LATENCY == 1) begin
            commit  = 1'b1;
            state_d = S_DONE;
          end else begin
            cnt_d   = CW'(LATENCY - 1);
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          commit  = 1'b1;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    err_d       = commit ? err_s : err_q;
    read_data_d = read_data_q;
    if (commit && err_s)     read_data_d = '0;
    else if (commit && rd_s) read_data_d = rd_ext;
  end

  // Control and result registers, cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      mode_q      <= MMD_W;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      err_q       <= 1'b0;
      read_data_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mode_q      <= mode_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      err_q       <= err_d;
      read_data_q <= read_data_d;
    end
  end

  // A held reset blocks the write, so an abandoned access never lands.
  assign mem_we = rst_n & wr_s & ~err_s & ((LATENCY == 0) | commit);

  // Byte-enabled read-modify-write into the backing array.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; its contents survive rst_n by design.
    if (mem_we) begin
      if (be[0]) mem[addr_s[AW+1:2]][7:0]   <= wr_lanes[7:0];
      if (be[1]) mem[addr_s[AW+1:2]][15:8]  <= wr_lanes[15:8];
      if (be[2]) mem[addr_s[AW+1:2]][23:16] <= wr_lanes[23:16];
      if (be[3]) mem[addr_s[AW+1:2]][31:24] <= wr_lanes[31:24];
    end
  end

  assign stall    = rst_n & (LATENCY > 0) &
                    (((state_q == S_IDLE) & req) | (state_q == S_WAIT));
  assign readData = (LATENCY == 0) ? (err_s ? 32'h0 : rd_ext) : read_data_q;
  assign alignErr = (LATENCY == 0) ? (req & err_s) : ((state_q == S_DONE) & err_q);

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a LATENCY=2 and a LATENCY=0 instance, each
// checked against a word-array reference model using plain arithmetic.
module tb_data_mem_responder;
  import data_mem_responder_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr2, wd2, addr0, wd0, rdata2, rdata0;
  mmd_t        mode2, mode0;
  logic        rd2, wr2, rd0, wr0, stall2, stall0, aerr2, aerr0;
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] m2 [1024];
  logic [31:0] m0 [1024];
  logic [31:0] r;

  always #5 clk = ~clk;

  data_mem_responder #(.LATENCY(2), .DEPTH_WORDS(1024)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .address(addr2), .writeData(wd2), .mode(mode2),
    .memRead(rd2), .memWrite(wr2), .readData(rdata2), .stall(stall2), .alignErr(aerr2)
  );

  data_mem_responder #(.LATENCY(0), .DEPTH_WORDS(1024)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .address(addr0), .writeData(wd0), .mode(mode0),
    .memRead(rd0), .memWrite(wr0), .readData(rdata0), .stall(stall0), .alignErr(aerr0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ext_load(input logic [31:0] word, input logic [1:0] off,
                                           input mmd_t m);
    logic [31:0] v;
    int sh = 8 * off;
    case (m)
      MMD_BS:  begin v = (word >> sh) & 32'hFF;   if (v >= 32'h80)   v = v - 32'h100;   end
      MMD_BU:  v = (word >> sh) & 32'hFF;
      MMD_HS:  begin v = (word >> sh) & 32'hFFFF; if (v >= 32'h8000) v = v - 32'h10000; end
      MMD_HU:  v = (word >> sh) & 32'hFFFF;
      default: v = word;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] merge_store(input logic [31:0] word, input logic [31:0] wd,
                                              input logic [1:0] off, input mmd_t m);
    logic [31:0] mask, val;
    int sh = 8 * off;
    case (m)
      MMD_BS, MMD_BU: begin mask = 32'hFF << sh;   val = (wd & 32'hFF) << sh;   end
      MMD_HS, MMD_HU: begin mask = 32'hFFFF << sh; val = (wd & 32'hFFFF) << sh; end
      default:        begin mask = 32'hFFFFFFFF;   val = wd;                    end
    endcase
    return (word & ~mask) | val;
  endfunction

  function automatic bit is_err(input logic rd, input logic wr, input logic [31:0] a,
                                input mmd_t m);
    if (rd && wr) return 1'b1;
    if ((m == MMD_HS || m == MMD_HU) && a[0]) return 1'b1;
    if (m == MMD_W && a[1:0] != 2'b00) return 1'b1;
    return 1'b0;
  endfunction

  // One access on the LATENCY=2 port, driven just after a rising edge in IDLE.
  task automatic op2(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                     input mmd_t m, output logic [31:0] got);
    logic [31:0] exp;
    bit          err;
    int          n;
    err = is_err(rd, wr, a, m);
    exp = err ? 32'h0 : ext_load(m2[a[11:2]], a[1:0], m);
    rd2 = rd; wr2 = wr; addr2 = a; wd2 = d; mode2 = m;
    n = 0;
    @(negedge clk);
    while (stall2 === 1'b1 && n < 8) begin
      n++;
      @(negedge clk);
    end
    check("l2_stall_cycles", 32'(n), 32'd2);
    check("l2_align_err", 32'(aerr2), 32'(err));
    if (rd || err) check("l2_read_data", rdata2, exp);
    if (wr && !err) m2[a[11:2]] = merge_store(m2[a[11:2]], d, a[1:0], m);
    got = rdata2;
    @(posedge clk);
    #1;
    rd2 = 1'b0; wr2 = 1'b0;
  endtask

  // One cycle on the zero-wait port; outputs are combinational, stores land at the edge.
  task automatic op0(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                     input mmd_t m, output logic [31:0] got);
    logic [31:0] exp;
    bit          err;
    err = is_err(rd, wr, a, m);
    exp = err ? 32'h0 : ext_load(m0[a[11:2]], a[1:0], m);
    rd0 = rd; wr0 = wr; addr0 = a; wd0 = d; mode0 = m;
    @(negedge clk);
    check("l0_stall", 32'(stall0), 32'd0);
    check("l0_align_err", 32'(aerr0), 32'(err));
    if (rd || err) check("l0_read_data", rdata0, exp);
    got = rdata0;
    @(posedge clk);
    if (wr && !err) m0[a[11:2]] = merge_store(m0[a[11:2]], d, a[1:0], m);
    #1;
  endtask

  function automatic logic [31:0] rand_addr(input int max_word);
    logic [31:0] hi;
    hi = $urandom();
    return (hi & 32'hFFFFF000) | (32'($urandom_range(0, max_word)) << 2) |
           32'($urandom_range(0, 3));
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    logic [31:0] a;
    int          kind;
    mmd_t        m;

    // Reset with a load request held: stall must stay low and outputs cleared.
    rst_n = 1'b0;
    rd2 = 1'b1; wr2 = 1'b0; addr2 = 32'h40; wd2 = '0; mode2 = MMD_W;
    rd0 = 1'b0; wr0 = 1'b0; addr0 = '0;    wd0 = '0; mode0 = MMD_W;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_stall", 32'(stall2), 32'd0);
    check("reset_align_err", 32'(aerr2), 32'd0);
    check("reset_read_data", rdata2, 32'h0);
    check("reset_stall_l0", 32'(stall0), 32'd0);
    rd2 = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill the working windows with known random words.
    for (int i = 0; i < 64; i++) op2(1'b0, 1'b1, 32'(i * 4), $urandom(), MMD_W, r);
    for (int i = 0; i < 16; i++) op0(1'b0, 1'b1, 32'(i * 4), $urandom(), MMD_W, r);

    // Word store / load round trip.
    op2(1'b0, 1'b1, 32'h40, 32'hDEADBEEF, MMD_W, r);
    op2(1'b1, 1'b0, 32'h40, 32'h0, MMD_W, r);
    check("dir_word_load", r, 32'hDEADBEEF);

    // Byte lanes and extension over a cleared word.
    op2(1'b0, 1'b1, 32'h40, 32'h0, MMD_W, r);
    op2(1'b0, 1'b1, 32'h41, 32'hAAAAAA7F, MMD_BU, r);
    op2(1'b1, 1'b0, 32'h41, 32'h0, MMD_BS, r);
    check("dir_byte_s_7f", r, 32'h0000007F);
    op2(1'b0, 1'b1, 32'h42, 32'h55555580, MMD_BS, r);
    op2(1'b1, 1'b0, 32'h42, 32'h0, MMD_BS, r);
    check("dir_byte_s_80", r, 32'hFFFFFF80);
    op2(1'b1, 1'b0, 32'h42, 32'h0, MMD_BU, r);
    check("dir_byte_u_80", r, 32'h00000080);
    op2(1'b1, 1'b0, 32'h40, 32'h0, MMD_W, r);
    check("dir_word_after_bytes", r, 32'h00807F00);

    // Misaligned word load: normal timing, error pulse, zero data, array intact.
    op2(1'b1, 1'b0, 32'h42, 32'h0, MMD_W, r);
    check("dir_misaligned_data", r, 32'h0);
    op2(1'b1, 1'b0, 32'h40, 32'h0, MMD_W, r);
    check("dir_misaligned_intact", r, 32'h00807F00);

    // Half lanes.
    op2(1'b0, 1'b1, 32'h46, 32'h1234BEEF, MMD_HU, r);
    op2(1'b1, 1'b0, 32'h46, 32'h0, MMD_HS, r);
    check("dir_half_s", r, 32'hFFFFBEEF);
    op2(1'b1, 1'b0, 32'h46, 32'h0, MMD_HU, r);
    check("dir_half_u", r, 32'h0000BEEF);

    // Reset in the first WAIT cycle of a store abandons it.
    rd2 = 1'b0; wr2 = 1'b1; addr2 = 32'h80; wd2 = 32'h12345678; mode2 = MMD_W;
    @(posedge clk);
    #2;
    check("rst_wait_stall_before", 32'(stall2), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_wait_stall_drop", 32'(stall2), 32'd0);
    check("rst_wait_read_data", rdata2, 32'h0);
    check("rst_wait_align_err", 32'(aerr2), 32'd0);
    wr2 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    op2(1'b1, 1'b0, 32'h80, 32'h0, MMD_W, r);

    // Randomized mix of loads, stores and conflicting requests.
    for (int i = 0; i < 80; i++) begin
      a    = rand_addr(63);
      kind = $urandom_range(0, 9);
      m    = mmd_t'($urandom_range(0, 4));
      op2(kind == 0 || kind > 4, kind <= 4, a, $urandom(), m, r);
    end

    // Zero-wait: store then load next cycle, and address wrap-around.
    op0(1'b0, 1'b1, 32'h10, 32'hCAFEF00D, MMD_W, r);
    op0(1'b1, 1'b0, 32'h10, 32'h0, MMD_W, r);
    check("l0_store_load", r, 32'hCAFEF00D);
    op0(1'b1, 1'b0, 32'h1010, 32'h0, MMD_W, r);
    check("l0_alias", r, 32'hCAFEF00D);
    for (int i = 0; i < 40; i++) begin
      a    = rand_addr(15);
      kind = $urandom_range(0, 9);
      m    = mmd_t'($urandom_range(0, 4));
      op0(kind == 0 || kind > 4, kind <= 4, a, $urandom(), m, r);
    end
    rd0 = 1'b0; wr0 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
